// File: rtl/angle_recover_q21.sv
// Vectoring-mode CORDIC: turns a (cos, sin) Q1.23 pair into an angle in [0, 2*pi)
// (Q3.21) and an unscaled magnitude (Q2.23, includes the CORDIC gain K).
module angle_recover_q21 #(
    parameter int N_ITER = 21,
    parameter int GUARD  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] cos_in,
    input  logic [23:0] sin_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] theta_out,
    output logic [24:0] mag_out,
    output logic [1:0]  o_dbg_state
);

    localparam int W  = 24 + GUARD;
    localparam int ZW = 26;
    localparam int IW = 5;

    localparam logic signed [ZW-1:0] C_2PI     = 26'sd13176795;
    localparam logic signed [ZW-1:0] C_PI      = 26'sd6588397;
    localparam logic signed [W-1:0]  C_MAG_MAX = W'(2**25 - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never drops and data never changes while waiting for ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // atan(2^-i) in Q3.21, rounded to nearest.
    function automatic logic signed [ZW-1:0] atan_q21(input logic [IW-1:0] idx);
        case (idx)
            5'd0:    return 26'sd1647099;
            5'd1:    return 26'sd972340;
            5'd2:    return 26'sd513757;
            5'd3:    return 26'sd260791;
            5'd4:    return 26'sd130902;
            5'd5:    return 26'sd65515;
            5'd6:    return 26'sd32765;
            5'd7:    return 26'sd16384;
            5'd8:    return 26'sd8192;
            5'd9:    return 26'sd4096;
            5'd10:   return 26'sd2048;
            5'd11:   return 26'sd1024;
            5'd12:   return 26'sd512;
            5'd13:   return 26'sd256;
            5'd14:   return 26'sd128;
            5'd15:   return 26'sd64;
            5'd16:   return 26'sd32;
            5'd17:   return 26'sd16;
            5'd18:   return 26'sd8;
            5'd19:   return 26'sd4;
            5'd20:   return 26'sd2;
            5'd21:   return 26'sd1;
            default: return '0;
        endcase
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic signed [W-1:0]    r_x;
    logic signed [W-1:0]    r_y;
    logic signed [ZW-1:0]   r_z;
    logic [IW-1:0]          r_iter;
    logic                   r_zero;
    logic [23:0]            r_theta;
    logic [24:0]            r_mag;
    logic                   r_out_valid;

    logic signed [W-1:0]    w_cos_ext;
    logic signed [W-1:0]    w_sin_ext;
    logic signed [W-1:0]    w_x_sh;
    logic signed [W-1:0]    w_y_sh;
    logic signed [ZW-1:0]   w_atan;
    logic                   w_last;
    logic [23:0]            w_theta;
    logic [24:0]            w_mag;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign theta_out   = r_theta;
    assign mag_out     = r_mag;
    assign o_dbg_state = r_state;

    assign w_cos_ext = {{GUARD{cos_in[23]}}, cos_in};
    assign w_sin_ext = {{GUARD{sin_in[23]}}, sin_in};
    assign w_x_sh    = r_x >>> r_iter;
    assign w_y_sh    = r_y >>> r_iter;
    assign w_atan    = atan_q21(r_iter);
    // ROT lasts N_ITER+1 cycles: the extra one folds z into [0, 2*pi) and
    // registers the outputs.
    assign w_last    = (r_iter == IW'(N_ITER));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_ROT;
            S_ROT:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_theta = 24'(r_z);
        if (r_zero) begin
            w_theta = '0;
        end else if (r_z[ZW-1]) begin
            w_theta = 24'(r_z + C_2PI);
        end else if (r_z >= C_2PI) begin
            w_theta = 24'(r_z - C_2PI);
        end
    end

    always_comb begin
        w_mag = r_x[24:0];
        if (r_x[W-1]) begin
            w_mag = '0;
        end else if (r_x > C_MAG_MAX) begin
            w_mag = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_iter      <= '0;
            r_zero      <= 1'b0;
            r_theta     <= '0;
            r_mag       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Left half-plane: rotate by pi first so the
                        // micro-rotations only need to cover +/- pi/2.
                        if (cos_in[23]) begin
                            r_x <= -w_cos_ext;
                            r_y <= -w_sin_ext;
                            r_z <= C_PI;
                        end else begin
                            r_x <= w_cos_ext;
                            r_y <= w_sin_ext;
                            r_z <= '0;
                        end
                        r_zero <= (cos_in == 24'd0) && (sin_in == 24'd0);
                        r_iter <= '0;
                    end
                end
                S_ROT: begin
                    if (w_last) begin
                        r_theta     <= w_theta;
                        r_mag       <= w_mag;
                        r_out_valid <= 1'b1;
                    end else begin
                        if (!r_y[W-1]) begin
                            r_x <= r_x + w_y_sh;
                            r_y <= r_y - w_x_sh;
                            r_z <= r_z + w_atan;
                        end else begin
                            r_x <= r_x - w_y_sh;
                            r_y <= r_y + w_x_sh;
                            r_z <= r_z - w_atan;
                        end
                        r_iter <= r_iter + 5'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
